instr_fetch_decode_ctrl: RTL and testbench

Multi-cycle fetch/decode controller that drives the R-type/I-type datapath. It fetches 32-bit RV64I instructions from instruction memory over a req/ack handshake and decodes R-type (opcode 0110011) and OP-IMM (opcode 0010011) instructions. It presents register indices, immediate, ALUSrc and ALU_CO to the datapath and pulses RegWrite once per retired instruction. It sits upstream of the datapath and is the producer of every control input the datapath consumes.

---
 rtl/instr_fetch_decode_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch_decode_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode_ctrl.sv
// Fetch/decode controller for the R-type/OP-IMM datapath: FETCH, DECODE, EXECUTE, WRITEBACK, 4 cycles per legal instruction at zero wait.
// Backpressure: imem_req holds with a stable address until imem_ack. Each wait cycle adds one cycle. Illegal words take 2 cycles.
module instr_fetch_decode_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  register_1,
  output logic [5:0]  register_2,
  output logic [5:0]  write_register,
  output logic [11:0] imm,
  output logic        ALUSrc,
  output logic [3:0]  ALU_CO,
  output logic        RegWrite,
  output logic        illegal,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       ecall;
    logic       alusrc;
    logic [3:0] alu_co;
  } dec_t;

  localparam logic [6:0]  OPC_R   = 7'b0110011;
  localparam logic [6:0]  OPC_I   = 7'b0010011;
  localparam logic [31:0] ECALL_W = 32'h0000_0073;

  localparam logic [3:0] CO_AND  = 4'b0000;
  localparam logic [3:0] CO_OR   = 4'b0001;
  localparam logic [3:0] CO_ADD  = 4'b0010;
  localparam logic [3:0] CO_XOR  = 4'b0011;
  localparam logic [3:0] CO_SUB  = 4'b0110;
  localparam logic [3:0] CO_SLT  = 4'b0111;
  localparam logic [3:0] CO_SLL  = 4'b1000;
  localparam logic [3:0] CO_SRL  = 4'b1001;
  localparam logic [3:0] CO_SRA  = 4'b1010;
  localparam logic [3:0] CO_SLTU = 4'b1011;

  state_t      state;
  logic [63:0] pc;
  logic [31:0] ir;
  dec_t        dec;

  // funct3 -> ALU code for the non-alternate encodings shared by both formats
  function automatic logic [3:0] base_co(input logic [2:0] f3);
    case (f3)
      3'b000:  base_co = CO_ADD;
      3'b001:  base_co = CO_SLL;
      3'b010:  base_co = CO_SLT;
      3'b011:  base_co = CO_SLTU;
      3'b100:  base_co = CO_XOR;
      3'b101:  base_co = CO_SRL;
      3'b110:  base_co = CO_OR;
      default: base_co = CO_AND;
    endcase
  endfunction

  always_comb begin
    dec = '0;
    if (ir == ECALL_W) begin
      dec.ecall = 1'b1;
    end else if (ir[6:0] == OPC_R) begin
      dec.alusrc = 1'b0;
      if (ir[31:25] == 7'b0000000) begin
        dec.legal  = 1'b1;
        dec.alu_co = base_co(ir[14:12]);
      end else if (ir[31:25] == 7'b0100000 && ir[14:12] == 3'b000) begin
        dec.legal  = 1'b1;
        dec.alu_co = CO_SUB;
      end else if (ir[31:25] == 7'b0100000 && ir[14:12] == 3'b101) begin
        dec.legal  = 1'b1;
        dec.alu_co = CO_SRA;
      end
    end else if (ir[6:0] == OPC_I) begin
      dec.alusrc = 1'b1;
      case (ir[14:12])
        // RV64 shifts carry a 6-bit shamt, so only instr[31:26] is a qualifier
        3'b001: begin
          dec.legal  = (ir[31:26] == 6'b000000);
          dec.alu_co = CO_SLL;
        end
        3'b101: begin
          if (ir[31:26] == 6'b000000) begin
            dec.legal  = 1'b1;
            dec.alu_co = CO_SRL;
          end else if (ir[31:26] == 6'b010000) begin
            dec.legal  = 1'b1;
            dec.alu_co = CO_SRA;
          end
        end
        default: begin
          dec.legal  = 1'b1;
          dec.alu_co = base_co(ir[14:12]);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      ir             <= '0;
      imem_req       <= 1'b0;
      register_1     <= '0;
      register_2     <= '0;
      write_register <= '0;
      imm            <= '0;
      ALUSrc         <= 1'b0;
      ALU_CO         <= '0;
      RegWrite       <= 1'b0;
      illegal        <= 1'b0;
      halted         <= 1'b0;
      retired        <= '0;
    end else begin
      RegWrite <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec.ecall) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (dec.legal) begin
            register_1     <= {1'b0, ir[19:15]};
            register_2     <= {1'b0, ir[24:20]};
            write_register <= {1'b0, ir[11:7]};
            imm            <= ir[31:20];
            ALUSrc         <= dec.alusrc;
            ALU_CO         <= dec.alu_co;
            state          <= S_EXECUTE;
          end else begin
            illegal  <= 1'b1;
            pc       <= pc + 64'd4;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_EXECUTE: begin
          RegWrite <= (write_register[4:0] != 5'd0);
          state    <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          pc       <= pc + 64'd4;
          retired  <= retired + 32'd1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: begin
          imem_req <= 1'b0;
          halted   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_instr_fetch_decode_ctrl.sv
// Bench for instr_fetch_decode_ctrl: directed instruction words, expected events queued at issue and
// checked by an independent monitor as RegWrite, retire, illegal and halt events appear.
module tb_instr_fetch_decode_ctrl;

  localparam int K_WRITE   = 0;
  localparam int K_RETIRE  = 1;
  localparam int K_ILLEGAL = 2;
  localparam int K_HALT    = 3;

  typedef struct {
    int          kind;
    logic [5:0]  r1;
    logic [5:0]  r2;
    logic [5:0]  wr;
    logic [11:0] imm;
    logic        src;
    logic [3:0]  co;
    logic [31:0] ret;
    logic [63:0] addr;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  register_1;
  logic [5:0]  register_2;
  logic [5:0]  write_register;
  logic [11:0] imm;
  logic        ALUSrc;
  logic [3:0]  ALU_CO;
  logic        RegWrite;
  logic        illegal;
  logic        halted;
  logic [31:0] retired;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  logic [63:0] exp_pc = 64'h0;
  logic [31:0] exp_ret = 32'h0;
  logic        prev_req = 1'b0;
  logic        prev_halt = 1'b0;
  logic [31:0] prev_ret = 32'h0;

  instr_fetch_decode_ctrl #(.RESET_PC(64'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .register_1(register_1),
    .register_2(register_2),
    .write_register(write_register),
    .imm(imm),
    .ALUSrc(ALUSrc),
    .ALU_CO(ALU_CO),
    .RegWrite(RegWrite),
    .illegal(illegal),
    .halted(halted),
    .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: kind %0d seen, want none (t=%0t)", k, $time);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", 64'(k), 64'(e.kind));
    case (k)
      K_WRITE, K_RETIRE: begin
        chk("register_1", register_1, e.r1);
        chk("register_2", register_2, e.r2);
        chk("write_register", write_register, e.wr);
        chk("imm", imm, e.imm);
        chk("ALUSrc", ALUSrc, e.src);
        chk("ALU_CO", ALU_CO, e.co);
        chk("retired", retired, e.ret);
        chk("imem_addr", imem_addr, e.addr);
        if (k == K_WRITE) chk("latency", 64'(cyc - rise_cyc + 1), 64'(e.lat));
      end
      K_ILLEGAL: begin
        chk("illegal_retired", retired, e.ret);
        chk("illegal_pc", imem_addr, e.addr);
        chk("illegal_no_regwrite", RegWrite, 1'b0);
      end
      default: begin
        chk("halt_req", imem_req, 1'b0);
        chk("halt_pc", imem_addr, e.addr);
        chk("halt_retired", retired, e.ret);
      end
    endcase
  endtask

  // Monitor: samples on the falling edge, away from DUT updates
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req  = imem_req;
        prev_halt = halted;
        prev_ret  = retired;
        continue;
      end
      if (imem_req && !prev_req) rise_cyc = cyc;
      if (RegWrite) observe(K_WRITE);
      if (retired !== prev_ret) observe(K_RETIRE);
      if (illegal) observe(K_ILLEGAL);
      if (halted && !prev_halt) observe(K_HALT);
      prev_req  = imem_req;
      prev_halt = halted;
      prev_ret  = retired;
    end
  end

  // Serve one fetch: wait for the request, stall 'waits' cycles, then ack for one cycle
  task automatic fetch(input logic [31:0] word, input int waits);
    int n = 0;
    while (imem_req !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (imem_req !== 1'b1) begin
      chk("fetch_req_timeout", imem_req, 1'b1);
      return;
    end
    chk("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      chk("wait_req_hold", imem_req, 1'b1);
      chk("wait_addr_hold", imem_addr, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic legal(input logic [31:0] w, input int waits, input logic [5:0] r1, r2, rd,
                       input logic [11:0] im, input logic src, input logic [3:0] co);
    exp_t e;
    e.kind = K_WRITE; e.r1 = r1; e.r2 = r2; e.wr = rd; e.imm = im; e.src = src; e.co = co;
    e.ret = exp_ret; e.addr = exp_pc; e.lat = 4 + waits;
    if (rd != 6'd0) sb.push_back(e);
    e.kind = K_RETIRE; e.ret = exp_ret + 32'd1; e.addr = exp_pc + 64'd4;
    sb.push_back(e);
    fetch(w, waits);
    exp_pc  = exp_pc + 64'd4;
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic bad(input logic [31:0] w);
    exp_t e;
    e = '{kind: K_ILLEGAL, r1: 0, r2: 0, wr: 0, imm: 0, src: 0, co: 0,
          ret: exp_ret, addr: exp_pc + 64'd4, lat: 0};
    sb.push_back(e);
    fetch(w, 0);
    exp_pc = exp_pc + 64'd4;
  endtask

  task automatic ecall();
    exp_t e;
    e = '{kind: K_HALT, r1: 0, r2: 0, wr: 0, imm: 0, src: 0, co: 0,
          ret: exp_ret, addr: exp_pc, lat: 0};
    sb.push_back(e);
    fetch(32'h0000_0073, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 64'h0);
    chk("rst_register_1", register_1, 6'd0);
    chk("rst_register_2", register_2, 6'd0);
    chk("rst_write_register", write_register, 6'd0);
    chk("rst_imm", imm, 12'h0);
    chk("rst_ALUSrc", ALUSrc, 1'b0);
    chk("rst_ALU_CO", ALU_CO, 4'h0);
    chk("rst_RegWrite", RegWrite, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_req", imem_req, 1'b0);
    pulse_start();

    //    word          wait r1 r2  rd  imm     src co
    legal(32'h002081B3, 0,   1, 2,  3,  12'h002, 0, 4'b0010); // add  x3,x1,x2
    legal(32'hFFF00293, 0,   0, 31, 5,  12'hFFF, 1, 4'b0010); // addi x5,x0,-1
    legal(32'h402081B3, 0,   1, 2,  3,  12'h402, 0, 4'b0110); // sub  x3,x1,x2
    legal(32'h4030D293, 0,   1, 3,  5,  12'h403, 1, 4'b1010); // srai x5,x1,3
    bad(32'h0000_0003);                                        // load
    legal(32'h00100013, 0,   0, 1,  0,  12'h001, 1, 4'b0010); // addi x0,x0,1
    legal(32'h0020E3B3, 3,   1, 2,  7,  12'h002, 0, 4'b0001); // or   x7,x1,x2
    bad(32'h402091B3);                                         // funct7=0100000 with sll
    bad(32'h40209193);                                         // slli with bad top bits
    legal(32'h0020B333, 1,   1, 2,  6,  12'h002, 0, 4'b1011); // sltu x6,x1,x2
    ecall();

    repeat (2) @(posedge clk);
    #1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("halt_ignores_start_req", imem_req, 1'b0);
      chk("halt_sticky", halted, 1'b1);
      @(posedge clk); #1;
    end

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clears_halted", halted, 1'b0);
    chk("rst_clears_retired", retired, 32'h0);
    rst_n   = 1'b1;
    exp_pc  = 64'h0;
    exp_ret = 32'h0;
    pulse_start();

    // Reset lands while the instruction sits in EXECUTE: no write may follow
    fetch(32'h002081B3, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pc", imem_addr, 64'h0);
    chk("midrst_req", imem_req, 1'b0);
    chk("midrst_regwrite", RegWrite, 1'b0);
    chk("midrst_retired", retired, 32'h0);
    chk("midrst_write_register", write_register, 6'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_regwrite", RegWrite, 1'b0);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
